wb_shared_bus: RTL

Parametrised Wishbone classic shared-bus interconnect with MASTER_COUNT masters and SLAVE_COUNT slaves. It has a registered round-robin arbiter, base/mask address decoding, and an internal error responder for unmapped addresses. A per-transfer watchdog guards against slaves that never respond. It sits between the compute engines / host bridge and the SRAM / register slaves, and supersedes the fixed 2x2 interconnect.

---
 rtl/wb_shared_bus.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/wb_shared_bus.sv
// Wishbone classic shared bus: registered round-robin arbiter, base/mask slave decode,
// an error responder for unmapped addresses and a per-transfer watchdog.
module wb_shared_bus #(
    parameter int MASTER_COUNT = 2,
    parameter int SLAVE_COUNT  = 2,
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 8,
    parameter int SEL_WIDTH    = DATA_WIDTH / 8,
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_BASE = {24'h800000, 24'h000000},
    parameter logic [SLAVE_COUNT*ADDR_WIDTH-1:0] SLAVE_MASK = {24'h800000, 24'hFFFFFC},
    parameter int TIMEOUT_CYCLES = 255,
    localparam int GNT_W = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [MASTER_COUNT-1:0]            wbm_cyc_i,
    input  logic [MASTER_COUNT-1:0]            wbm_stb_i,
    input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] wbm_adr_i,
    input  logic [MASTER_COUNT-1:0]            wbm_we_i,
    input  logic [MASTER_COUNT*SEL_WIDTH-1:0]  wbm_sel_i,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0] wbm_dat_i,
    output logic [MASTER_COUNT-1:0]            wbm_ack_o,
    output logic [MASTER_COUNT-1:0]            wbm_err_o,
    output logic [MASTER_COUNT-1:0]            wbm_rty_o,
    output logic [DATA_WIDTH-1:0]              wbm_dat_o,
    output logic [SLAVE_COUNT-1:0]             wbs_cyc_o,
    output logic [SLAVE_COUNT-1:0]             wbs_stb_o,
    output logic [ADDR_WIDTH-1:0]              wbs_adr_o,
    output logic                               wbs_we_o,
    output logic [SEL_WIDTH-1:0]               wbs_sel_o,
    output logic [DATA_WIDTH-1:0]              wbs_dat_o,
    input  logic [SLAVE_COUNT-1:0]             wbs_ack_i,
    input  logic [SLAVE_COUNT-1:0]             wbs_err_i,
    input  logic [SLAVE_COUNT-1:0]             wbs_rty_i,
    input  logic [SLAVE_COUNT*DATA_WIDTH-1:0]  wbs_dat_i,
    output logic [GNT_W-1:0]                   gnt_o,
    output logic                               gnt_valid_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [GNT_W-1:0]       gnt_q, gnt_d;
    logic                   gnt_valid_q, gnt_valid_d;
    logic                   err_q, err_d;
    logic                   tmo_q, tmo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   bus_cyc, bus_stb;
    logic [ADDR_WIDTH-1:0]  bus_adr;
    logic [SLAVE_COUNT-1:0] slv_sel;
    logic                   mapped;
    int                     slv_idx;
    logic                   s_ack, s_err, s_rty, slv_resp, wd_err;
    logic                   bus_ack, bus_err, bus_rty;

    // Round-robin search starting after the current owner; only when the owner has let go.
    always_comb begin
        logic found;
        int   idx;
        found       = 1'b0;
        idx         = 0;
        gnt_d       = gnt_q;
        gnt_valid_d = |wbm_cyc_i;
        if (!gnt_valid_q || !wbm_cyc_i[gnt_q]) begin
            for (int k = 1; k <= MASTER_COUNT; k++) begin
                idx = (int'(gnt_q) + k) % MASTER_COUNT;
                if (!found && wbm_cyc_i[idx]) begin
                    gnt_d = GNT_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    assign bus_cyc = gnt_valid_q & wbm_cyc_i[gnt_q];
    assign bus_stb = bus_cyc & wbm_stb_i[gnt_q];
    assign bus_adr = wbm_adr_i[int'(gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];

    assign wbs_adr_o = bus_adr;
    assign wbs_we_o  = wbm_we_i[gnt_q];
    assign wbs_sel_o = wbm_sel_i[int'(gnt_q)*SEL_WIDTH +: SEL_WIDTH];
    assign wbs_dat_o = wbm_dat_i[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        slv_sel = '0;
        mapped  = 1'b0;
        slv_idx = 0;
        for (int j = 0; j < SLAVE_COUNT; j++) begin
            if (!mapped && ((bus_adr & SLAVE_MASK[j*ADDR_WIDTH +: ADDR_WIDTH]) ==
                            (SLAVE_BASE[j*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[j*ADDR_WIDTH +: ADDR_WIDTH]))) begin
                slv_sel[j] = 1'b1;
                mapped     = 1'b1;
                slv_idx    = j;
            end
        end
    end

    assign wbs_cyc_o = {SLAVE_COUNT{bus_cyc}} & slv_sel;
    assign wbs_stb_o = {SLAVE_COUNT{bus_stb}} & slv_sel;

    assign s_ack    = |(wbs_ack_i & slv_sel);
    assign s_err    = |(wbs_err_i & slv_sel);
    assign s_rty    = |(wbs_rty_i & slv_sel);
    assign slv_resp = s_ack | s_err | s_rty;
    // A real slave answer in the timeout cycle takes precedence over the watchdog.
    assign wd_err   = tmo_q & bus_stb & ~slv_resp;

    assign bus_ack = bus_cyc & s_ack;
    assign bus_err = bus_cyc & (s_err | err_q | wd_err);
    assign bus_rty = bus_cyc & s_rty;

    always_comb begin
        wbm_ack_o        = '0;
        wbm_err_o        = '0;
        wbm_rty_o        = '0;
        wbm_ack_o[gnt_q] = bus_ack;
        wbm_err_o[gnt_q] = bus_err;
        wbm_rty_o[gnt_q] = bus_rty;
    end

    assign wbm_dat_o   = (gnt_valid_q && mapped) ? wbs_dat_i[slv_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign gnt_o       = gnt_q;
    assign gnt_valid_o = gnt_valid_q;

    assign err_d = bus_stb & ~mapped & ~err_q;

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = 1'b0;
        if (TIMEOUT_CYCLES > 0) begin
            if (!bus_stb || !mapped || slv_resp || tmo_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                cnt_d = '0;
                tmo_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q       <= GNT_W'(MASTER_COUNT - 1);
            gnt_valid_q <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
